counter_seq: RTL

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/counter_seq.sv
// Command sequencer for an external up/down counter: queues segment commands in a 2-deep FIFO
// and runs each one to its limit. Define COUNTER_SEQ_AUTO_REVERSE_EN for endless limit-to-limit ping-pong.
module counter_seq #(
  parameter int WIDTH = 8,
  parameter int MAX   = 100,
  parameter int MIN   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [3:0]       cmd_din,
  input  logic [3:0]       cmd_step,
  input  logic             cmd_up_down,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] seg_cnt,
  output logic             cnt_en,
  output logic             cnt_set,
  output logic             cnt_up_down,
  output logic [3:0]       cnt_din,
  output logic [3:0]       cnt_step,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic             cnt_finish
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic       load;
    logic [3:0] din;
    logic [3:0] step;
    logic       up_down;
  } cmd_t;

  cmd_t       fifo_mem [2];
  cmd_t       cmd_in;
  cmd_t       head;
  cmd_t       cur;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       term;
  logic       flip;
  state_t     state;
  state_t     state_next;

  // The counter's own limit flag plays no part in termination.
  logic unused_finish;
  assign unused_finish = cnt_finish;

  assign cmd_in     = {cmd_load, cmd_din, cmd_step, cmd_up_down};
  assign fifo_full  = (fifo_count == 2'd2);
  assign fifo_empty = (fifo_count == 2'd0);
  assign cmd_ready  = rst && !fifo_full && !abort;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];

  // NOTE: only pointers and occupancy are reset; entries are never read while empty,
  // so the storage array is left without a reset and maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else if (abort) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // First state of a freshly popped command; a zero step never enters RUN.
  function automatic state_t dispatch(input cmd_t c);
    if (c.load)              return LOAD;
    else if (c.step == 4'd0) return DONE;
    else                     return RUN;
  endfunction

  assign term = cur.up_down ? (cnt_count >= MAX_C) : (cnt_count <= MIN_C);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cnt_en     = 1'b0;
    cnt_set    = 1'b0;
    done       = 1'b0;
    flip       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = dispatch(head);
        end
      end
      LOAD: begin
        cnt_en     = 1'b1;
        cnt_set    = 1'b1;
        state_next = (cur.step == 4'd0) ? DONE : RUN;
      end
      RUN: begin
        cnt_en = !term;
        if (term) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = dispatch(head);
        end else begin
`ifdef COUNTER_SEQ_AUTO_REVERSE_EN
          flip       = 1'b1;
          state_next = (cur.step == 4'd0) ? DONE : RUN;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including the counter controls of this very cycle.
    if (abort) begin
      state_next = IDLE;
      pop        = 1'b0;
      cnt_en     = 1'b0;
      cnt_set    = 1'b0;
      done       = 1'b0;
      flip       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= '0;
    end else if (pop) begin
      cur <= head;
    end else if (flip) begin
      cur.up_down <= ~cur.up_down;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      seg_cnt <= '0;
    else if (done) seg_cnt <= seg_cnt + WIDTH'(1);
  end

  assign busy        = (state != IDLE) || !fifo_empty;
  assign cnt_din     = cur.din;
  assign cnt_step    = cur.step;
  assign cnt_up_down = cur.up_down;

endmodule
